// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the arbiter state, the write-request payload and the field widths.
package regfile_wb_arbiter_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Writes to the hard-wired zero register are accepted but must not write.
  function automatic wb_req_t to_write(input wb_req_t req);
    wb_req_t w;
    w = req;
    if (req.addr == REG_ZERO) w.be = '0;
    return w;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two writeback ports, the register-file write port and the hazard query.
// slave = arbiter side, master = pipeline/regfile side.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic              wb0_valid;
  logic              wb0_ready;
  logic [ADDR_W-1:0] wb0_addr;
  logic [BE_W-1:0]   wb0_be;
  logic [DATA_W-1:0] wb0_data;

  logic              wb1_valid;
  logic              wb1_ready;
  logic [ADDR_W-1:0] wb1_addr;
  logic [BE_W-1:0]   wb1_be;
  logic [DATA_W-1:0] wb1_data;

  logic [ADDR_W-1:0] Rd_addr;
  logic [BE_W-1:0]   Rd_write_byte_en;
  logic [DATA_W-1:0] Rd_in;

  logic [ADDR_W-1:0] pend_addr;
  logic              pend_hit;

  modport slave (
    input  wb0_valid, wb0_addr, wb0_be, wb0_data,
    output wb0_ready,
    input  wb1_valid, wb1_addr, wb1_be, wb1_data,
    output wb1_ready,
    output Rd_addr, Rd_write_byte_en, Rd_in,
    input  pend_addr,
    output pend_hit
  );

  modport master (
    output wb0_valid, wb0_addr, wb0_be, wb0_data,
    input  wb0_ready,
    output wb1_valid, wb1_addr, wb1_be, wb1_data,
    input  wb1_ready,
    input  Rd_addr, Rd_write_byte_en, Rd_in,
    output pend_addr,
    input  pend_hit
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo2.sv
// Two-entry synchronous FIFO for port-1 write requests.
// Both slots are exposed with per-slot valid bits so the parent can run hazard compares.
module wb_fifo2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  wb_req_t i_push_data,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty,
  output wb_req_t o_ent0,
  output wb_req_t o_ent1,
  output logic [1:0] o_ent_vld
);

  wb_req_t    r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head = r_mem[r_rptr];
  assign o_ent0 = r_mem[0];
  assign o_ent1 = r_mem[1];

  // A slot holds live data when the FIFO is full, or it is the head of a single entry.
  assign o_ent_vld[0] = o_full || ((r_count == 2'd1) && (r_rptr == 1'b0));
  assign o_ent_vld[1] = o_full || ((r_count == 2'd1) && (r_rptr == 1'b1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates pipeline (port 0) and multi-cycle-unit (port 1) writebacks onto one
// register-file write port; port 0 has priority, port 1 is queued and anti-starved.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  Clk,
  input logic                  Rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  wb_req_t          r_rd;

  wb_req_t    w_req0;
  wb_req_t    w_req1;
  wb_req_t    w_head;
  wb_req_t    w_ent0;
  wb_req_t    w_ent1;
  logic [1:0] w_ent_vld;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_hit0;
  logic       w_hit1;

  assign w_req0 = '{addr: bus.wb0_addr, be: bus.wb0_be, data: bus.wb0_data};
  assign w_req1 = '{addr: bus.wb1_addr, be: bus.wb1_be, data: bus.wb1_data};

  // Readies come from registered state only; reset forces both low.
  assign bus.wb0_ready = !Rst && (r_state == NORMAL);
  assign bus.wb1_ready = !Rst && !w_full;

  assign w_push   = bus.wb1_valid && bus.wb1_ready;
  assign w_grant0 = bus.wb0_valid && bus.wb0_ready;
  assign w_grant1 = !Rst && !w_empty && ((r_state == FORCE1) || !bus.wb0_valid);

  wb_fifo2 u_fifo (
    .i_clk       (Clk),
    .i_rst       (Rst),
    .i_push      (w_push),
    .i_push_data (w_req1),
    .i_pop       (w_grant1),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ent0      (w_ent0),
    .o_ent1      (w_ent1),
    .o_ent_vld   (w_ent_vld)
  );

  // Hazard query: any live queued entry that will actually write pend_addr.
  assign w_hit0 = w_ent_vld[0] && (w_ent0.addr == bus.pend_addr) && (w_ent0.be != '0);
  assign w_hit1 = w_ent_vld[1] && (w_ent1.addr == bus.pend_addr) && (w_ent1.be != '0);
  assign bus.pend_hit = !Rst && (bus.pend_addr != REG_ZERO) && (w_hit0 || w_hit1);

  assign bus.Rd_addr          = r_rd.addr;
  assign bus.Rd_write_byte_en = r_rd.be;
  assign bus.Rd_in            = r_rd.data;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
      r_rd         <= '0;
    end else begin
      if (w_grant0)      r_rd <= to_write(w_req0);
      else if (w_grant1) r_rd <= to_write(w_head);
      else               r_rd <= '0;

      case (r_state)
        NORMAL: begin
          if (w_empty || w_grant1) begin
            r_starve_cnt <= '0;
          end else if ((r_starve_cnt + 1'b1) == STARVE_LIM) begin
            r_state      <= FORCE1;
            r_starve_cnt <= '0;
          end else begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        FORCE1: begin
          r_state      <= NORMAL;
          r_starve_cnt <= '0;
        end
        default: begin
          r_state      <= NORMAL;
          r_starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expected write-port values.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ew(input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    return 64'({a, b, d});
  endfunction

  function automatic logic [63:0] rd();
    return 64'({bus.Rd_addr, bus.Rd_write_byte_en, bus.Rd_in});
  endfunction

  task automatic set0(input logic v, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    bus.wb0_valid = v;
    bus.wb0_addr  = a;
    bus.wb0_be    = b;
    bus.wb0_data  = d;
  endtask

  task automatic set1(input logic v, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    bus.wb1_valid = v;
    bus.wb1_addr  = a;
    bus.wb1_be    = b;
    bus.wb1_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set0(1'b0, 5'd0, 4'h0, 32'h0);
    set1(1'b0, 5'd0, 4'h0, 32'h0);
    bus.pend_addr = 5'd13;

    // Reset behaviour
    tick();
    tick();
    chk("rst_wb0_ready", 64'(bus.wb0_ready), 64'd0);
    chk("rst_wb1_ready", 64'(bus.wb1_ready), 64'd0);
    chk("rst_pend_hit",  64'(bus.pend_hit),  64'd0);
    chk("rst_rd",        rd(),               64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_wb0_ready", 64'(bus.wb0_ready), 64'd1);
    chk("post_rst_wb1_ready", 64'(bus.wb1_ready), 64'd1);

    // Port 0 alone: latency one, then idle zeros
    set0(1'b1, 5'd5, 4'hF, 32'h5555_6789);
    tick();
    chk("p0_lat1", rd(), ew(5'd5, 4'hF, 32'h5555_6789));
    set0(1'b0, 5'd0, 4'h0, 32'h0);
    tick();
    chk("p0_idle", rd(), 64'd0);

    // Write to register zero is accepted but disabled
    set0(1'b1, 5'd0, 4'hF, 32'hFFFF_FFFF);
    #1;
    chk("zero_ready", 64'(bus.wb0_ready), 64'd1);
    tick();
    chk("zero_be", 64'(bus.Rd_write_byte_en), 64'd0);
    set0(1'b0, 5'd0, 4'h0, 32'h0);
    tick();

    // Port 1 burst of 3; port 0 busy two cycles so the FIFO fills
    set0(1'b1, 5'd1, 4'hF, 32'h1111_0001);
    set1(1'b1, 5'd10, 4'hF, 32'hA000_000A);
    #1;
    chk("burst_rdy0", 64'(bus.wb1_ready), 64'd1);
    tick();
    chk("burst_e0", rd(), ew(5'd1, 4'hF, 32'h1111_0001));
    set0(1'b1, 5'd2, 4'hF, 32'h1111_0002);
    set1(1'b1, 5'd11, 4'hF, 32'hA000_000B);
    #1;
    chk("burst_rdy1", 64'(bus.wb1_ready), 64'd1);
    tick();
    chk("burst_e1", rd(), ew(5'd2, 4'hF, 32'h1111_0002));
    set0(1'b0, 5'd0, 4'h0, 32'h0);
    set1(1'b1, 5'd12, 4'hF, 32'hA000_000C);
    #1;
    chk("burst_full_rdy", 64'(bus.wb1_ready), 64'd0);
    tick();
    chk("burst_w10", rd(), ew(5'd10, 4'hF, 32'hA000_000A));
    chk("burst_rdy3", 64'(bus.wb1_ready), 64'd1);
    tick();
    chk("burst_w11", rd(), ew(5'd11, 4'hF, 32'hA000_000B));
    set1(1'b0, 5'd0, 4'h0, 32'h0);
    tick();
    chk("burst_w12", rd(), ew(5'd12, 4'hF, 32'hA000_000C));
    tick();
    chk("burst_drain", rd(), 64'd0);

    // Hazard query against a queued port-1 entry
    set0(1'b1, 5'd2, 4'hF, 32'h2222_0002);
    set1(1'b1, 5'd13, 4'hF, 32'hD000_000D);
    tick();
    chk("pend_p0", rd(), ew(5'd2, 4'hF, 32'h2222_0002));
    set0(1'b1, 5'd3, 4'hF, 32'h2222_0003);
    set1(1'b0, 5'd0, 4'h0, 32'h0);
    bus.pend_addr = 5'd13;
    #1;
    chk("pend_hit13", 64'(bus.pend_hit), 64'd1);
    bus.pend_addr = 5'd0;
    #1;
    chk("pend_hit0", 64'(bus.pend_hit), 64'd0);
    bus.pend_addr = 5'd14;
    #1;
    chk("pend_hit14", 64'(bus.pend_hit), 64'd0);
    tick();
    set0(1'b0, 5'd0, 4'h0, 32'h0);
    bus.pend_addr = 5'd13;
    #1;
    chk("pend_hit_still", 64'(bus.pend_hit), 64'd1);
    tick();
    chk("pend_retire", rd(), ew(5'd13, 4'hF, 32'hD000_000D));
    chk("pend_hit_after", 64'(bus.pend_hit), 64'd0);
    tick();

    // Starvation: both ports valid every cycle, addr 9 forced out on the 5th head cycle
    for (int c = 0; c <= 6; c++) begin
      set0(1'b1, 5'(16 + c), 4'hF, 32'(32'h3000_0000 + c));
      if (c == 0)      set1(1'b1, 5'd9,  4'h3, 32'h9999_0009);
      else if (c <= 5) set1(1'b1, 5'd20, 4'hF, 32'h2020_0014);
      else             set1(1'b0, 5'd0,  4'h0, 32'h0);
      #1;
      chk($sformatf("starve_rdy0_c%0d", c), 64'(bus.wb0_ready), (c == 5) ? 64'd0 : 64'd1);
      tick();
      if (c == 5) chk("starve_grant9", rd(), ew(5'd9, 4'h3, 32'h9999_0009));
      else        chk($sformatf("starve_p0_c%0d", c), rd(), ew(5'(16 + c), 4'hF, 32'(32'h3000_0000 + c)));
    end
    set0(1'b0, 5'd0, 4'h0, 32'h0);
    tick();
    chk("starve_w20", rd(), ew(5'd20, 4'hF, 32'h2020_0014));
    tick();
    chk("starve_drain", rd(), 64'd0);

    // Reset with two entries queued and FORCE1 about to be entered
    bus.pend_addr = 5'd25;
    for (int c = 0; c <= 3; c++) begin
      set0(1'b1, 5'(2 + c), 4'hF, 32'(32'h4000_0000 + c));
      if (c == 0)      set1(1'b1, 5'd25, 4'hF, 32'h2525_0019);
      else if (c == 1) set1(1'b1, 5'd26, 4'hF, 32'h2626_001A);
      else             set1(1'b0, 5'd0,  4'h0, 32'h0);
      tick();
    end
    #1;
    chk("rst_mid_hit_pre", 64'(bus.pend_hit), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rdy0", 64'(bus.wb0_ready), 64'd0);
    chk("rst_mid_rdy1", 64'(bus.wb1_ready), 64'd0);
    chk("rst_mid_hit",  64'(bus.pend_hit),  64'd0);
    tick();
    chk("rst_mid_rd", rd(), 64'd0);
    rst = 1'b0;
    set0(1'b0, 5'd0, 4'h0, 32'h0);
    #1;
    chk("rst_mid_normal", 64'(bus.wb0_ready), 64'd1);
    chk("rst_mid_empty",  64'(bus.wb1_ready), 64'd1);
    chk("rst_mid_hit_post", 64'(bus.pend_hit), 64'd0);
    tick();
    chk("rst_mid_nowrite0", rd(), 64'd0);
    tick();
    chk("rst_mid_nowrite1", rd(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
